issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Hazard controller that sequences the decode stage.
- Tracks in-flight destination registers, compares each decoded uop's rs1/rs2/rd against them, and drives source_not_ready back to the decoder. The decoder holds and redispatches the stalled uop.
- Increments the pending count for rd on issue and decrements it on writeback; a small FSM measures stall duration for deadlock detection.
- Sits between the decoder outputs and the execution unit and register-file write port.

Parameters:
NUM_REGS, 32, architectural register count
REG_ADDR_WIDTH, 5, register address width (log2 NUM_REGS)
CNT_WIDTH, 2, per-register pending-writer counter width; max in-flight writers per register = 2^CNT_WIDTH-1
STALL_LIMIT, 255, consecutive stall cycles before stall_timeout asserts

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
system_stall  input  1  downstream stall; blocks issue, no allocation
system_flush  input  1  pipeline flush; clears all tracking state
dec_uop_valid  input  1  decoder registered uop valid (before source_not_ready masking)
rs1  input  REG_ADDR_WIDTH  decoded source 1
rs2  input  REG_ADDR_WIDTH  decoded source 2
rd  input  REG_ADDR_WIDTH  decoded destination
rs1_valid  input  1  rs1 used
rs2_valid  input  1  rs2 used
rd_valid  input  1  rd written
wb_valid  input  1  register-file writeback this cycle
wb_rd  input  REG_ADDR_WIDTH  writeback destination
source_not_ready  output  1  combinational hazard to decoder
issue_fire  output  1  uop accepted this cycle
busy_vec  output  NUM_REGS  bit i = pending count of register i nonzero (registered)
stall_cycles  output  8  consecutive cycles in STALL, saturating at STALL_LIMIT
stall_timeout  output  1  stall_cycles == STALL_LIMIT
wb_underflow  output  1  sticky error: writeback to register with zero pending count

Behaviour:
- Reset (async, active-high): all counters 0, busy_vec 0, FSM IDLE, stall_cycles 0, stall_timeout 0, wb_underflow 0. source_not_ready and issue_fire are forced 0 while reset is high.
- x0 is never busy. rd==0 is never allocated. wb_rd==0 is ignored (no decrement, no underflow).
- Effective busy(r) = (cnt[r]!=0) && !(wb_valid && wb_rd==r && cnt[r]==1). Same-cycle writeback is bypassed by the register file.
- hazard = dec_uop_valid && ((rs1_valid && rs1!=0 && busy(rs1)) || (rs2_valid && rs2!=0 && busy(rs2)) || (rd_valid && rd!=0 && cnt[rd]==max && !(wb_valid && wb_rd==rd))).
- source_not_ready = hazard, zero latency, combinational.
- issue_fire = dec_uop_valid && !hazard && !system_stall && !system_flush.
- Counter update at posedge, per register r:
  - inc = issue_fire && rd_valid && rd==r && r!=0
  - dec = wb_valid && wb_rd==r && r!=0 && cnt[r]!=0
  - cnt[r] += inc - dec; inc and dec together leave cnt unchanged.
- wb_valid to r!=0 with cnt[r]==0: no decrement; wb_underflow set, held until reset (flush does not clear it).
- busy_vec[r] = (cnt[r]!=0), from registered counts, updated the cycle after issue or writeback.
- system_flush: next edge all counters 0, FSM IDLE, stall_cycles 0. Flush has priority over issue and writeback in that cycle.
- FSM:
  - IDLE -> STALL when hazard.
  - STALL -> IDLE when !hazard (including dec_uop_valid low).
  - STALL -> STALL while hazard. system_stall alone does not enter STALL.
- stall_cycles: 0 in IDLE. On entering STALL it is 1, then increments each cycle in STALL, saturating at STALL_LIMIT. Cleared on the transition to IDLE.
- stall_timeout: registered, high while stall_cycles==STALL_LIMIT.
- Read-after-write on the same cycle as issue: a subsequent uop sees the new count the next cycle. The decoder holds one uop per cycle, so no intra-cycle chaining is required.

Test Plan:
- Reset mid-operation: issue rd=5 (busy_vec[5]=1), assert reset async -> busy_vec==0, source_not_ready==0 immediately, stall_cycles==0.
- RAW stall: issue rd=3; next uop rs1=3 -> source_not_ready=1, issue_fire=0, stall_cycles 1,2,...; wb_valid, wb_rd=3 -> same cycle source_not_ready=0, issue_fire=1; next cycle busy_vec[3]=0, stall_cycles=0.
- x0 and counter saturation: uop rd=0 issued -> busy_vec==0. Issue rd=7 three times with CNT_WIDTH=2 -> 4th writer to rd=7 gets source_not_ready=1 until one wb to 7; simultaneous issue+wb to 7 keeps cnt=3.
- Flush priority: cnt[9]=2, same cycle system_flush=1, issue rd=9, wb_rd=9 -> next cycle all busy_vec=0, issue_fire was 0.
- Underflow: wb_valid, wb_rd=12 with cnt 0 -> wb_underflow=1, persists through system_flush, cleared only by reset.
- Timeout: STALL_LIMIT=4, hold hazard on rs2=6 -> stall_timeout=1 at 4th stall cycle and stays high; wb to 6 -> stall_timeout=0 next cycle.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Decode-stage hazard controller. Keeps a pending-writer count per
//   architectural register. It checks each decoded uop's sources and
//   destination against those counts. It raises source_not_ready so the
//   decoder holds the uop and presents it again. A small FSM measures how
//   long the decoder has been held, so that a deadlock can be detected.
//
// Ports
//   clk, reset                    system clock, async active-high reset
//   system_stall, system_flush    downstream stall (blocks issue) / flush (clears tracking)
//   dec_uop_valid                 decoder uop valid
//   rs1/rs2/rd (+ *_valid)        decoded operand addresses and use flags
//   wb_valid, wb_rd               register-file writeback
//   source_not_ready              combinational hazard back to the decoder
//   issue_fire                    uop accepted this cycle
//   busy_vec                      per-register "pending count nonzero", from registered counts
//   stall_cycles, stall_timeout   consecutive stall length (saturating) and limit flag
//   wb_underflow                  sticky: writeback to a register with no pending writer
//
// FSM
//   state | meaning
//   IDLE  | decoder not held by a hazard
//   STALL | decoder held by a hazard; stall_cycles counting

module issue_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 2,
  parameter int STALL_LIMIT    = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      system_stall,
  input  logic                      system_flush,
  input  logic                      dec_uop_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      rs1_valid,
  input  logic                      rs2_valid,
  input  logic                      rd_valid,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      source_not_ready,
  output logic                      issue_fire,
  output logic [NUM_REGS-1:0]       busy_vec,
  output logic [7:0]                stall_cycles,
  output logic                      stall_timeout,
  output logic                      wb_underflow
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [7:0]           STALL_MAX = 8'(STALL_LIMIT);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];
  logic [7:0]            stall_cycles_q, stall_cycles_d;
  logic                  stall_timeout_q, stall_timeout_d;
  logic                  wb_underflow_q, wb_underflow_d;

  logic                  rs1_busy, rs2_busy, rd_full;
  logic                  hazard;
  logic                  fire;
  logic [NUM_REGS-1:0]   inc_vec, dec_vec;

  // Hazard detection. A writeback retiring the last pending writer of a
  // source is bypassed by the register file, so that source is not busy.
  // A full destination counter can still take a new writer if a writeback
  // to it frees a slot in the same cycle.
  always_comb begin
    rs1_busy = (cnt_q[rs1] != '0) &&
               !(wb_valid && (wb_rd == rs1) && (cnt_q[rs1] == CNT_ONE));
    rs2_busy = (cnt_q[rs2] != '0) &&
               !(wb_valid && (wb_rd == rs2) && (cnt_q[rs2] == CNT_ONE));
    rd_full  = (cnt_q[rd] == CNT_MAX) && !(wb_valid && (wb_rd == rd));
    hazard   = dec_uop_valid &&
               ((rs1_valid && (rs1 != '0) && rs1_busy) ||
                (rs2_valid && (rs2 != '0) && rs2_busy) ||
                (rd_valid  && (rd  != '0) && rd_full));
    fire     = dec_uop_valid && !hazard && !system_stall && !system_flush && !reset;
  end

  // Pending-count update. When an issue and a writeback hit the same
  // register, the two cancel.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_vec[r] = fire && rd_valid && (rd == REG_ADDR_WIDTH'(r));
      dec_vec[r] = wb_valid && (wb_rd == REG_ADDR_WIDTH'(r)) && (cnt_q[r] != '0);
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (system_flush) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // Underflow is sticky through flush. Only reset clears it.
  always_comb begin
    wb_underflow_d = wb_underflow_q ||
                     (!system_flush && wb_valid && (wb_rd != '0) && (cnt_q[wb_rd] == '0));
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (system_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (hazard)  state_d = STALL;
        STALL:   if (!hazard) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs and stall-length tracking
  always_comb begin
    stall_cycles_d = '0;
    if (state_d == STALL) begin
      if (state_q == IDLE) begin
        stall_cycles_d = 8'd1;
      end else if (stall_cycles_q != STALL_MAX) begin
        stall_cycles_d = stall_cycles_q + 8'd1;
      end else begin
        stall_cycles_d = stall_cycles_q;
      end
    end
    stall_timeout_d  = (stall_cycles_d == STALL_MAX);

    source_not_ready = hazard && !reset;
    issue_fire       = fire;
    stall_cycles     = stall_cycles_q;
    stall_timeout    = stall_timeout_q;
    wb_underflow     = wb_underflow_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      stall_cycles_q  <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_cycles_q  <= stall_cycles_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      wb_underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      wb_underflow_q <= wb_underflow_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        system_stall, system_flush;
  logic        dec_uop_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_valid, rs2_valid, rd_valid;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        source_not_ready, issue_fire;
  logic [31:0] busy_vec;
  logic [7:0]  stall_cycles;
  logic        stall_timeout, wb_underflow;

  int n_pass = 0;
  int n_total = 0;

  issue_scoreboard #(
    .NUM_REGS(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2), .STALL_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .system_stall(system_stall), .system_flush(system_flush),
    .dec_uop_valid(dec_uop_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .rd_valid(rd_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .source_not_ready(source_not_ready), .issue_fire(issue_fire),
    .busy_vec(busy_vec), .stall_cycles(stall_cycles),
    .stall_timeout(stall_timeout), .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    system_stall = 0; system_flush = 0;
    dec_uop_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
    rs1_valid = 0; rs2_valid = 0; rd_valid = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic uop(input logic [4:0] a1, input logic v1, input logic [4:0] a2,
                     input logic v2, input logic [4:0] ad, input logic vd);
    dec_uop_valid = 1;
    rs1 = a1; rs1_valid = v1; rs2 = a2; rs2_valid = v2; rd = ad; rd_valid = vd;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_valid = 1; wb_rd = a;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    uop(5'd1, 1, 5'd2, 1, 5'd3, 1);
    #1;
    chk("rst_busy", busy_vec, 0);
    chk("rst_snr", source_not_ready, 0);
    chk("rst_fire", issue_fire, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_tmo", stall_timeout, 0);
    chk("rst_uflow", wb_underflow, 0);
    idle_inputs();
    tick();
    reset = 0;
    tick();

    // reset mid-operation
    uop(5'd0, 0, 5'd0, 0, 5'd5, 1);
    #1 chk("r5_fire", issue_fire, 1);
    tick();
    idle_inputs();
    chk("r5_busy", busy_vec, 32'h1 << 5);
    uop(5'd5, 1, 5'd0, 0, 5'd0, 0);
    #1 chk("r5_hz", source_not_ready, 1);
    tick();
    chk("r5_stall1", stall_cycles, 1);
    #1 reset = 1;
    #1;
    chk("arst_busy", busy_vec, 0);
    chk("arst_snr", source_not_ready, 0);
    chk("arst_stall", stall_cycles, 0);
    idle_inputs();
    tick();
    reset = 0;
    tick();

    // RAW stall with writeback bypass
    uop(5'd0, 0, 5'd0, 0, 5'd3, 1);
    tick();
    idle_inputs();
    chk("raw_busy", busy_vec, 32'h1 << 3);
    uop(5'd3, 1, 5'd0, 0, 5'd0, 0);
    #1;
    chk("raw_snr", source_not_ready, 1);
    chk("raw_fire", issue_fire, 0);
    tick(); chk("raw_sc1", stall_cycles, 1);
    tick(); chk("raw_sc2", stall_cycles, 2);
    tick(); chk("raw_sc3", stall_cycles, 3);
    wb(5'd3);
    #1;
    chk("raw_byp_snr", source_not_ready, 0);
    chk("raw_byp_fire", issue_fire, 1);
    tick();
    idle_inputs();
    chk("raw_busy0", busy_vec, 0);
    chk("raw_sc0", stall_cycles, 0);

    // x0 never allocated
    uop(5'd0, 0, 5'd0, 0, 5'd0, 1);
    #1 chk("x0_fire", issue_fire, 1);
    tick();
    idle_inputs();
    chk("x0_busy", busy_vec, 0);

    // counter saturation on rd=7
    uop(5'd0, 0, 5'd0, 0, 5'd7, 1);
    #1 chk("sat_fire1", issue_fire, 1);
    tick();
    chk("sat_fire2", issue_fire, 1);
    tick();
    chk("sat_fire3", issue_fire, 1);
    tick();
    chk("sat_busy", busy_vec, 32'h1 << 7);
    chk("sat_snr", source_not_ready, 1);
    chk("sat_fire4", issue_fire, 0);
    tick();
    chk("sat_sc1", stall_cycles, 1);
    wb(5'd7);
    #1;
    chk("sat_wb_snr", source_not_ready, 0);
    chk("sat_wb_fire", issue_fire, 1);
    tick();
    wb_valid = 0;
    #1;
    chk("sat_hold_snr", source_not_ready, 1);
    chk("sat_hold_busy", busy_vec, 32'h1 << 7);
    chk("sat_hold_sc", stall_cycles, 0);
    idle_inputs();
    wb(5'd7);
    tick(); tick();
    chk("sat_drain2_busy", busy_vec, 32'h1 << 7);
    tick();
    idle_inputs();
    chk("sat_drain_busy", busy_vec, 0);
    chk("sat_no_uflow", wb_underflow, 0);

    // system_stall alone blocks issue but does not enter STALL
    uop(5'd1, 1, 5'd2, 1, 5'd8, 1);
    system_stall = 1;
    #1;
    chk("sst_fire", issue_fire, 0);
    chk("sst_snr", source_not_ready, 0);
    tick();
    idle_inputs();
    chk("sst_sc", stall_cycles, 0);
    chk("sst_busy", busy_vec, 0);

    // flush priority over issue and writeback
    uop(5'd0, 0, 5'd0, 0, 5'd9, 1);
    tick(); tick();
    idle_inputs();
    chk("fl_busy2", busy_vec, 32'h1 << 9);
    uop(5'd0, 0, 5'd0, 0, 5'd9, 1);
    wb(5'd9);
    system_flush = 1;
    #1 chk("fl_fire", issue_fire, 0);
    tick();
    idle_inputs();
    chk("fl_busy0", busy_vec, 0);
    uop(5'd9, 1, 5'd0, 0, 5'd0, 0);
    #1 chk("fl_cnt0_snr", source_not_ready, 0);
    idle_inputs();

    // writeback to x0 is ignored; underflow on reg 12 is sticky through flush
    wb(5'd0);
    tick();
    chk("x0wb_uflow", wb_underflow, 0);
    wb(5'd12);
    #1 chk("uf_pre", wb_underflow, 0);
    tick();
    idle_inputs();
    chk("uf_set", wb_underflow, 1);
    system_flush = 1;
    tick();
    idle_inputs();
    chk("uf_flush", wb_underflow, 1);
    #1 reset = 1;
    #1 chk("uf_reset", wb_underflow, 0);
    tick();
    reset = 0;
    tick();

    // stall timeout at limit 4 on rs2=6
    uop(5'd0, 0, 5'd0, 0, 5'd6, 1);
    tick();
    idle_inputs();
    uop(5'd0, 0, 5'd6, 1, 5'd0, 0);
    tick(); chk("to_sc1", stall_cycles, 1);
    tick(); tick();
    chk("to_sc3", stall_cycles, 3);
    chk("to_tmo3", stall_timeout, 0);
    tick();
    chk("to_sc4", stall_cycles, 4);
    chk("to_tmo4", stall_timeout, 1);
    tick();
    chk("to_sat_sc", stall_cycles, 4);
    chk("to_sat_tmo", stall_timeout, 1);
    wb(5'd6);
    #1 chk("to_wb_fire", issue_fire, 1);
    tick();
    idle_inputs();
    chk("to_clr_tmo", stall_timeout, 0);
    chk("to_clr_sc", stall_cycles, 0);
    chk("to_clr_busy", busy_vec, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
